// File: rtl/base_splat_fifo.sv
// Multi-lane compacting FIFO: packs valid input lanes, lowest lane first, into
// a circular buffer and drains one entry per cycle through a valid/ready port.
module base_splat_fifo #(
    parameter int unsigned ways    = 4,
    parameter int unsigned width   = 8,
    parameter int unsigned depth   = 16,
    parameter int unsigned aw      = $clog2(depth),
    parameter int unsigned n_width = $clog2(ways + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [0:ways-1]        i_v,
    output logic                   i_r,
    input  logic [0:ways*width-1]  i_d,
    output logic                   o_v,
    input  logic                   o_r,
    output logic [0:width-1]       o_d,
    output logic [0:aw]            o_cnt
);

    localparam int unsigned CW = aw + 1;

    if (depth < ways || (depth & (depth - 1)) != 0) begin : g_bad_params
        $error("base_splat_fifo: depth must be a power of two and >= ways");
    end

    logic [aw-1:0]      wp_q, wp_d;
    logic [aw-1:0]      rp_q, rp_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               i_r_q, i_r_d;
    logic               o_v_q, o_v_d;
    logic [width-1:0]   mem_q [depth];

    logic [n_width-1:0] off [ways];
    logic [aw-1:0]      wr_addr [ways];
    logic [n_width-1:0] npush;
    logic               push;
    logic               pop;

    // Per-lane prefix count gives each valid lane its slot past the write pointer.
    always_comb begin
        off[0] = '0;
        for (int unsigned k = 1; k < ways; k++) begin
            off[k] = off[k-1] + n_width'(i_v[k-1]);
        end
        npush = off[ways-1] + n_width'(i_v[ways-1]);
        for (int unsigned k = 0; k < ways; k++) begin
            wr_addr[k] = wp_q + aw'(off[k]);
        end
    end

    // Next-state: ready/valid are precomputed from the next occupancy so both
    // stay registered and independent of i_v/o_r within the cycle.
    always_comb begin
        push  = i_r_q && (|i_v);
        pop   = o_v_q && o_r;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push) begin
            wp_d = wp_q + aw'(npush);
        end
        if (pop) begin
            rp_d = rp_q + aw'(1);
        end
        cnt_d = cnt_q + (push ? CW'(npush) : CW'(0)) - (pop ? CW'(1) : CW'(0));
        i_r_d = (CW'(depth) - cnt_d) >= CW'(ways);
        o_v_d = (cnt_d != CW'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            i_r_q <= 1'b1;
            o_v_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            i_r_q <= i_r_d;
            o_v_q <= o_v_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int unsigned k = 0; k < ways; k++) begin
                if (i_v[k]) begin
                    mem_q[wr_addr[k]] <= i_d[k*width +: width];
                end
            end
        end
    end

    assign i_r   = i_r_q;
    assign o_v   = o_v_q;
    assign o_cnt = cnt_q;
    assign o_d   = mem_q[rp_q];

endmodule

// File: tb/tb_base_splat_fifo.sv
// Directed bench for base_splat_fifo with default parameters (ways=4, width=8, depth=16).
module tb_base_splat_fifo;

    logic        clk;
    logic        reset;
    logic [0:3]  i_v;
    logic        i_r;
    logic [0:31] i_d;
    logic        o_v;
    logic        o_r;
    logic [0:7]  o_d;
    logic [0:4]  o_cnt;

    int tests;
    int fails;

    base_splat_fifo dut (
        .clk   (clk),
        .reset (reset),
        .i_v   (i_v),
        .i_r   (i_r),
        .i_d   (i_d),
        .o_v   (o_v),
        .o_r   (o_r),
        .o_d   (o_d),
        .o_cnt (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        i_v   = '0;
        i_d   = '0;
        o_r   = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ov", 32'(o_v), 0);
        chk("rst_cnt", 32'(o_cnt), 0);
        chk("rst_ir", 32'(i_r), 1);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Sparse compaction: lanes 0 and 2 only
        i_v = 4'b1010;
        i_d = {8'hA0, 8'h55, 8'hA2, 8'h66};
        tick();
        i_v = '0;
        chk("sparse_cnt", 32'(o_cnt), 2);
        chk("sparse_ov", 32'(o_v), 1);
        chk("sparse_d0", 32'(o_d), 32'hA0);
        o_r = 1'b1;
        tick();
        chk("sparse_d1", 32'(o_d), 32'hA2);
        chk("sparse_cnt1", 32'(o_cnt), 1);
        tick();
        chk("sparse_empty", 32'(o_v), 0);
        o_r = 1'b0;

        // Fill to full: 0x30..0x3F
        for (int j = 0; j < 3; j++) begin
            i_v = 4'b1111;
            i_d = {8'(8'h30 + 4*j), 8'(8'h31 + 4*j), 8'(8'h32 + 4*j), 8'(8'h33 + 4*j)};
            tick();
        end
        i_v = '0;
        chk("fill12_cnt", 32'(o_cnt), 12);
        chk("fill12_ir", 32'(i_r), 1);
        i_v = 4'b1111;
        i_d = {8'h3C, 8'h3D, 8'h3E, 8'h3F};
        tick();
        chk("full_cnt", 32'(o_cnt), 16);
        chk("full_ir", 32'(i_r), 0);
        chk("full_ov", 32'(o_v), 1);
        i_d = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tick();
        chk("full_hold_cnt", 32'(o_cnt), 16);
        chk("full_hold_d", 32'(o_d), 32'h30);

        // Threshold: single-lane request is still refused at cnt=13
        i_v = 4'b0001;
        i_d = {8'h00, 8'h00, 8'h00, 8'hEE};
        o_r = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("thr_pop_d", 32'(o_d), 32'(8'h30 + j));
            tick();
        end
        o_r = 1'b0;
        chk("thr13_cnt", 32'(o_cnt), 13);
        chk("thr13_ir", 32'(i_r), 0);
        tick();
        chk("thr13_hold_cnt", 32'(o_cnt), 13);
        chk("thr13_hold_d", 32'(o_d), 32'h33);
        o_r = 1'b1;
        tick();
        o_r = 1'b0;
        i_v = '0;
        chk("thr12_cnt", 32'(o_cnt), 12);
        chk("thr12_ir", 32'(i_r), 1);
        chk("thr12_d", 32'(o_d), 32'h34);

        // Drain down to a single entry
        o_r = 1'b1;
        for (int j = 0; j < 11; j++) begin
            chk("drain_d", 32'(o_d), 32'(8'h34 + j));
            tick();
        end
        chk("one_cnt", 32'(o_cnt), 1);

        // Simultaneous push (lanes 1..3) and pop
        i_v = 4'b0111;
        i_d = {8'h00, 8'hB1, 8'hB2, 8'hB3};
        chk("pp_head", 32'(o_d), 32'h3F);
        tick();
        i_v = '0;
        chk("pp_cnt", 32'(o_cnt), 3);
        chk("pp_d1", 32'(o_d), 32'hB1);
        tick();
        chk("pp_d2", 32'(o_d), 32'hB2);
        tick();
        chk("pp_d3", 32'(o_d), 32'hB3);
        tick();
        chk("pp_empty", 32'(o_v), 0);

        // Advance both pointers from 5 to 14 with 9 filler entries
        o_r = 1'b0;
        i_d = {8'h77, 8'h77, 8'h77, 8'h77};
        i_v = 4'b1111;
        tick();
        tick();
        i_v = 4'b1000;
        tick();
        i_v = '0;
        chk("filler_cnt", 32'(o_cnt), 9);
        o_r = 1'b1;
        for (int j = 0; j < 9; j++) tick();
        o_r = 1'b0;
        chk("filler_empty", 32'(o_v), 0);

        // Wrap: one push straddles mem[15]/mem[0]
        i_v = 4'b1111;
        i_d = {8'h10, 8'h11, 8'h12, 8'h13};
        tick();
        i_v = '0;
        chk("wrap_cnt", 32'(o_cnt), 4);
        o_r = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("wrap_d", 32'(o_d), 32'(8'h10 + j));
            tick();
        end
        chk("wrap_empty", 32'(o_v), 0);
        o_r = 1'b0;

        // Reset mid-stream at cnt=5, asserted away from any clock edge
        i_v = 4'b1111;
        i_d = {8'h20, 8'h21, 8'h22, 8'h23};
        tick();
        i_v = 4'b1000;
        i_d = {8'h24, 8'h00, 8'h00, 8'h00};
        tick();
        i_v = '0;
        chk("pre_rst_cnt", 32'(o_cnt), 5);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_ov", 32'(o_v), 0);
        chk("mid_rst_cnt", 32'(o_cnt), 0);
        chk("mid_rst_ir", 32'(i_r), 1);
        tick();
        reset = 1'b0;
        chk("post_rst_cnt", 32'(o_cnt), 0);
        i_v = 4'b0100;
        i_d = {8'h00, 8'hC1, 8'h00, 8'h00};
        tick();
        i_v = '0;
        chk("post_rst_ov", 32'(o_v), 1);
        chk("post_rst_d", 32'(o_d), 32'hC1);
        chk("post_rst_cnt1", 32'(o_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
